data_ram: RTL
=============

# data_ram

Word-organised, byte-writable data RAM on the RAM side of the memory controller. Consumes the controller's word address, pre-aligned write data, byte lane selects and store/load strobes. Returns the raw 32-bit word on `ramDataRead` after a fixed, parameterised latency; the controller then extracts and extends that word. Read data is pipelined, so the block accepts one load or store every cycle.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words. Must be a power of two, at least 2.
- `READ_LATENCY`, default 1: cycles from the load strobe to valid read data. Legal range is 1 to 4.
- `clk` input, 1 bit: single clock, rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `addressIn` input, `DATA_WIDTH`: byte address. Bits [1:0] are ignored; the word index is bits [AW+1:2], where AW = log2(DEPTH_WORDS).
- `dataWriteIn` input, `DATA_WIDTH`: write word, already lane-aligned.
- `byteSelect` input, 4 bits: write enable per byte lane. Bit n controls bits [8n+7:8n].
- `ramStore` input, 1 bit: store strobe, sampled each cycle.
- `ramLoad` input, 1 bit: load strobe, sampled each cycle.
- `ramDataRead` output, `DATA_WIDTH`: read word. Holds its value between loads.
- `readValid` output, 1 bit: one-cycle pulse when `ramDataRead` updates.
- `addrError` output, 1 bit: one-cycle pulse reporting an out-of-range access.

## Operation
- Range check: an access is out of range when `addressIn` ≥ DEPTH_WORDS×4, i.e. any bit above AW+1 is set.
- Store, when `ramStore`=1 and the address is in range:
  - each lane with `byteSelect[n]`=1 is written at the rising edge;
  - lanes with a 0 select keep their old value;
  - `byteSelect`=0 is a legal no-op.
- Load, when `ramLoad`=1:
  - the addressed word is sampled at this edge and enters a delay line of depth READ_LATENCY;
  - each stage carries {valid, err, data}.
- Out-of-range store: no array write; `addrError` pulses in the next cycle.
- Out-of-range load: data is returned as 0 and `addrError` pulses together with that load's `readValid`.
- Load and store together on the same address: read-before-write. The load returns the pre-store word; the store still commits.
- Back-to-back loads: one result per cycle, in order. There is no stall path and no backpressure.
- Store in cycle t followed by a load of the same word in cycle t+1: the load returns the new data.
- Memory contents are not reset and power up undefined. Benches must write before reading.

## Timing
- Reset values: `ramDataRead`=0, `readValid`=0, `addrError`=0, all delay-line valid bits 0.
- Reset is asynchronous assert and synchronous deassert at the system level. Loads in flight when reset asserts are discarded; no `readValid` follows for them.
- The load at edge t gives `readValid`=1 and data in the cycle after edge t+READ_LATENCY-1.
  - READ_LATENCY=1: data is visible in the cycle immediately after the load edge.
- Store-error `addrError` pulse: the cycle after the edge.
- Load-error `addrError` pulse: aligned with `readValid`.
- Two error sources in the same cycle (a store error at t and a load error from an earlier edge): `addrError` is a single OR'd pulse.
- `ramDataRead` changes only when `readValid`=1. Otherwise it holds its last value.

## Structure
- Shared package `mem_pkg`:
  - `DATA_WIDTH` (32, from the global definitions);
  - `BYTES_PER_WORD`=4 and `BYTE_OFFSET_BITS`=2;
  - a typedef for the 4-bit lane mask.
- One sub-module, `ram_read_pipe`:
  - parameterised shift register of {valid, err, data}, depth READ_LATENCY;
  - async active-low reset on the valid/err bits only.
- The top level holds the array, the per-lane write enables and the range check.

## Test plan
- Store 0xDEADBEEF to 0x10 with mask 0xF, then load 0x10 → `readValid` after READ_LATENCY, data 0xDEADBEEF, `addrError`=0.
- Store 0x0000AA00 to 0x10 with mask 0x2 over 0xDEADBEEF, then load → 0xDEADAAEF. With mask 0x0 → word unchanged.
- Same-cycle load and store to 0x20 (old 0x11111111, new 0x22222222, mask 0xF) → load returns 0x11111111; the next load returns 0x22222222.
- Loads to 0x00, 0x04, 0x08 on consecutive cycles with READ_LATENCY=3 → three consecutive `readValid` pulses, with data in issue order.
- Load at DEPTH_WORDS×4 → data 0 with `addrError` and `readValid` together. Store at the same address → `addrError` the next cycle and no word altered (check words 0 and DEPTH_WORDS-1).
- Assert `reset_n`=0 with two loads in flight → outputs 0 immediately, no `readValid` after release, and a previously stored word is still readable.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the RAM side of the memory controller.
package mem_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int BYTES_PER_WORD   = 4;
  localparam int BYTE_OFFSET_BITS = 2;

  // One write-enable bit per byte lane; bit n covers bits [8n+7:8n].
  typedef logic [BYTES_PER_WORD-1:0] lane_mask_t;

endpackage

// File: rtl/ram_read_pipe.sv
// Fixed-latency delay line for load results. Each stage carries
// {valid, err, data}. Only valid/err are reset, so a reset drops every
// load in flight. Data registers load only when a valid word reaches
// them, which makes the last stage hold its word between loads.
module ram_read_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      err_q;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  // Valid/err shift chain, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_valid & in_err;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  // Data shift chain, advanced only alongside a valid bit.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      data_q[0] <= in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (valid_q[i-1]) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_err   = err_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/data_ram.sv
// Word-organised, byte-writable data RAM. Accepts one load and/or store
// per cycle, returns raw words after READ_LATENCY cycles and flags
// out-of-range accesses.
//
// Strobe/valid semantics: ramStore and ramLoad are sampled on every rising
// edge and are always accepted (there is no ready; the RAM never stalls).
// readValid is a one-cycle pulse per accepted load, in issue order, and
// ramDataRead is meaningful and updated only in that cycle; it holds the
// last returned word otherwise. addrError pulses the cycle after an
// out-of-range store, and together with readValid for an out-of-range load.
module data_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] addressIn,
  input  logic [DATA_WIDTH-1:0] dataWriteIn,
  input  lane_mask_t            byteSelect,
  input  logic                  ramStore,
  input  logic                  ramLoad,
  output logic [DATA_WIDTH-1:0] ramDataRead,
  output logic                  readValid,
  output logic                  addrError
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic                  in_range;
  logic [AW-1:0]         word_idx;
  logic [DATA_WIDTH-1:0] read_word;
  logic                  store_err_q;
  logic                  have_data_q;
  logic                  pipe_valid;
  logic                  pipe_err;
  logic [DATA_WIDTH-1:0] pipe_data;

  // Any address bit above the word index makes the access out of range.
  assign in_range = ((addressIn >> (AW + BYTE_OFFSET_BITS)) == '0);
  assign word_idx = addressIn[AW+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS];

  // Per-lane array write; unselected lanes keep their old bytes.
  always_ff @(posedge clk) begin
    if (ramStore && in_range) begin
      for (int n = 0; n < BYTES_PER_WORD; n++) begin
        if (byteSelect[n]) begin
          mem[word_idx][8*n +: 8] <= dataWriteIn[8*n +: 8];
        end
      end
    end
  end

  // Combinational read of the current word; the pipe samples it at the
  // same edge the store commits, which gives read-before-write.
  assign read_word = in_range ? mem[word_idx] : '0;

  ram_read_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (ramLoad),
    .in_err    (~in_range),
    .in_data   (read_word),
    .out_valid (pipe_valid),
    .out_err   (pipe_err),
    .out_data  (pipe_data)
  );

  // Store-error pulse and the flag that a word has been returned since reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_err_q <= 1'b0;
      have_data_q <= 1'b0;
    end else begin
      store_err_q <= ramStore & ~in_range;
      if (pipe_valid) begin
        have_data_q <= 1'b1;
      end
    end
  end

  // The pipe's data is not reset, so mask it until the first result
  // after reset arrives; from then on the last stage holds the word.
  assign ramDataRead = (have_data_q | pipe_valid) ? pipe_data : '0;
  assign readValid   = pipe_valid;
  assign addrError   = store_err_q | (pipe_valid & pipe_err);

endmodule
